// File: rtl/present_pkg.sv
// ---------------------------------------------------------------------------
// present_pkg
// Shared definitions for the PRESENT-80 key schedule blocks.
//   KEY_W          width of the full key register (80)
//   RK_W           width of one round key (64)
//   IDX_W          width of the round-key index (enough for 1..63)
//   ks_state_t     scheduler FSM states
//   PRESENT_SBOX   the PRESENT 4-bit S-box as a lookup table
// ---------------------------------------------------------------------------
package present_pkg;

   localparam int KEY_W = 80;
   localparam int RK_W  = 64;
   localparam int IDX_W = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } ks_state_t;

   localparam logic [3:0] PRESENT_SBOX [16] = '{
      4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
   };

endpackage

// File: rtl/present_key_update.sv
// ---------------------------------------------------------------------------
// present_key_update
// One round of the PRESENT-80 key update, purely combinational so it can be
// reused by an unrolled schedule as well as by the sequential scheduler.
// Ports:
//   key_i   [79:0]  current key register
//   cnt_i   [4:0]   round counter mixed into bits [19:15]
//   nkey_o  [79:0]  updated key register
// ---------------------------------------------------------------------------
module present_key_update
   import present_pkg::*;
(
   input  logic [KEY_W-1:0] key_i,
   input  logic [4:0]       cnt_i,
   output logic [KEY_W-1:0] nkey_o
);

   logic [KEY_W-1:0] rotated;

   // Rotating left by 61 is the same as rotating right by 19.
   assign rotated = {key_i[18:0], key_i[79:19]};

   // Only the top nibble goes through the S-box; the counter lands on [19:15].
   always_comb begin
      nkey_o         = rotated;
      nkey_o[79:76]  = PRESENT_SBOX[rotated[79:76]];
      nkey_o[19:15]  = rotated[19:15] ^ cnt_i;
   end

endmodule

// File: rtl/present_key_scheduler.sv
// ---------------------------------------------------------------------------
// present_key_scheduler
// Sequencer for the PRESENT-80 key schedule. Loads the master key on start
// and streams round keys K1..K(NUM_ROUNDS+1) over a valid/ready handshake.
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   start      load key_in and begin (honoured only in IDLE)
//   key_in     80-bit master key
//   abort      abandon the schedule, back to IDLE with the key cleared
//   busy       high in RUN and DONE
//   rk_valid   round_key / rk_index are valid
//   rk_ready   consumer accepts the current round key
//   round_key  current round key, key_reg[79:16]
//   rk_index   index of round_key, 1..NUM_ROUNDS+1
//   done       one-cycle pulse after the last key is accepted
// ---------------------------------------------------------------------------
module present_key_scheduler
   import present_pkg::*;
#(
   parameter int NUM_ROUNDS = 31
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [KEY_W-1:0]  key_in,
   input  logic              abort,
   output logic              busy,
   output logic              rk_valid,
   input  logic              rk_ready,
   output logic [RK_W-1:0]   round_key,
   output logic [IDX_W-1:0]  rk_index,
   output logic              done
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS + 1);

   ks_state_t        state_q, state_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [KEY_W-1:0] nextKey;

   // The counter fed to the update is the index of the key being retired,
   // so K(i+1) is derived with counter value i.
   present_key_update uUpdate (
      .key_i  (key_q),
      .cnt_i  (idx_q[4:0]),
      .nkey_o (nextKey)
   );

   // State, key and index registers; reset clears the key so nothing leaks.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         key_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         idx_q   <= idx_d;
      end
   end

   // Next-state logic. Abort always takes priority and scrubs the key; while
   // valid is up without ready everything simply holds.
   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (abort) begin
               key_d = '0;
               idx_d = '0;
            end else if (start) begin
               key_d   = key_in;
               idx_d   = IDX_W'(1);
               state_d = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
               key_d   = '0;
               idx_d   = '0;
            end else if (rk_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  key_d = nextKey;
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            if (abort) begin
               key_d = '0;
               idx_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            key_d   = '0;
            idx_d   = '0;
         end
      endcase
   end

   // All outputs decode straight from registers, so rk_ready never reaches
   // round_key combinationally.
   assign busy      = (state_q == RUN) || (state_q == DONE);
   assign rk_valid  = (state_q == RUN);
   assign done      = (state_q == DONE);
   assign round_key = key_q[79:16];
   assign rk_index  = idx_q;

endmodule

// File: tb/tb_present_key_scheduler.sv
// ---------------------------------------------------------------------------
// tb_present_key_scheduler
// Directed bench for the PRESENT-80 key scheduler. Round keys are compared
// with an independent key-schedule model and hand-computed constants, and the
// collected keys are run through a reference PRESENT encryption whose result
// is compared with the published test-vector ciphertexts.
// ---------------------------------------------------------------------------
module tb_present_key_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [79:0] key_in;
   logic        abort;
   logic        busy;
   logic        rk_valid;
   logic        rk_ready;
   logic [63:0] round_key;
   logic [5:0]  rk_index;
   logic        done;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [63:0] expKeys [1:32];
   logic [63:0] gotKeys [1:32];

   localparam logic [79:0] KEY_ZERO = 80'h0;
   localparam logic [79:0] KEY_ONES = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;

   present_key_scheduler #(.NUM_ROUNDS(31)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .key_in    (key_in),
      .abort     (abort),
      .busy      (busy),
      .rk_valid  (rk_valid),
      .rk_ready  (rk_ready),
      .round_key (round_key),
      .rk_index  (rk_index),
      .done      (done)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Drive inputs, then advance one clock and settle just past the edge.
   task automatic applyStimulus(input logic s, input logic a, input logic r,
                                input logic [79:0] k);
      start    = s;
      abort    = a;
      rk_ready = r;
      key_in   = k;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] sboxRef(input logic [3:0] x);
      case (x)
         4'h0: sboxRef = 4'hC;  4'h1: sboxRef = 4'h5;
         4'h2: sboxRef = 4'h6;  4'h3: sboxRef = 4'hB;
         4'h4: sboxRef = 4'h9;  4'h5: sboxRef = 4'h0;
         4'h6: sboxRef = 4'hA;  4'h7: sboxRef = 4'hD;
         4'h8: sboxRef = 4'h3;  4'h9: sboxRef = 4'hE;
         4'hA: sboxRef = 4'hF;  4'hB: sboxRef = 4'h8;
         4'hC: sboxRef = 4'h4;  4'hD: sboxRef = 4'h7;
         4'hE: sboxRef = 4'h1;  default: sboxRef = 4'h2;
      endcase
   endfunction

   // Reference key schedule: fills expKeys[1..32] for a master key.
   task automatic buildExpected(input logic [79:0] master);
      logic [79:0] k;
      logic [79:0] t;
      k = master;
      for (int r = 1; r <= 32; r++) begin
         expKeys[r] = k[79:16];
         t = {k[18:0], k[79:19]};
         t[79:76] = sboxRef(t[79:76]);
         t[19:15] = t[19:15] ^ 5'(r);
         k = t;
      end
   endtask

   // Reference PRESENT-80 encryption using the keys collected from the DUT.
   function automatic logic [63:0] encryptRef(input logic [63:0] pt);
      logic [63:0] s;
      logic [63:0] p;
      s = pt;
      for (int r = 1; r <= 31; r++) begin
         s = s ^ gotKeys[r];
         for (int n = 0; n < 16; n++) s[n*4 +: 4] = sboxRef(s[n*4 +: 4]);
         p = '0;
         for (int b = 0; b < 63; b++) p[(16 * b) % 63] = s[b];
         p[63] = s[63];
         s = p;
      end
      encryptRef = s ^ gotKeys[32];
   endfunction

   // Runs one schedule. actionKind: 0 none, 1 start pulse with altKey,
   // 2 abort, 3 reset -- each fired once when rk_index reaches actionIdx.
   task automatic runSchedule(input logic [79:0] key, input bit randomStall,
                              input int actionIdx, input int actionKind,
                              input logic [79:0] altKey, input string name,
                              output bit completed);
      int  expIdx;
      int  cycles;
      bit  fired;
      bit  r;
      bit  s;
      bit  a;
      bit  wasValid;
      buildExpected(key);
      for (int i = 1; i <= 32; i++) gotKeys[i] = '0;
      completed = 1'b0;
      fired     = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b1, key);
      cycles = 1;
      expIdx = 1;
      checkOutput({name, " first valid"}, 64'(rk_valid), 64'd1);
      for (int n = 0; n < 2000; n++) begin
         r = randomStall ? 1'($urandom_range(0, 1)) : 1'b1;
         s = 1'b0;
         a = 1'b0;
         wasValid = rk_valid;
         checkOutput({name, " valid held"}, 64'(rk_valid), 64'd1);
         checkOutput({name, " index"}, 64'(rk_index), 64'(expIdx));
         checkOutput({name, " key"}, round_key, expKeys[expIdx]);
         if (r) gotKeys[expIdx] = round_key;
         if (!fired && actionKind != 0 && int'(rk_index) == actionIdx) begin
            fired = 1'b1;
            if (actionKind == 1) s = 1'b1;
            if (actionKind == 2) a = 1'b1;
            if (actionKind == 3) begin
               rst = 1'b1;
               applyStimulus(1'b0, 1'b0, r, key);
               rst = 1'b0;
               checkOutput({name, " rst valid"}, 64'(rk_valid), 64'd0);
               checkOutput({name, " rst busy"}, 64'(busy), 64'd0);
               checkOutput({name, " rst done"}, 64'(done), 64'd0);
               checkOutput({name, " rst key"}, round_key, 64'd0);
               checkOutput({name, " rst index"}, 64'(rk_index), 64'd0);
               return;
            end
         end
         applyStimulus(s, a, r, s ? altKey : key);
         cycles++;
         if (a) begin
            checkOutput({name, " abort valid"}, 64'(rk_valid), 64'd0);
            checkOutput({name, " abort busy"}, 64'(busy), 64'd0);
            checkOutput({name, " abort done"}, 64'(done), 64'd0);
            checkOutput({name, " abort key"}, round_key, 64'd0);
            applyStimulus(1'b0, 1'b0, 1'b1, key);
            checkOutput({name, " abort no done"}, 64'(done), 64'd0);
            checkOutput({name, " abort idle"}, 64'(busy), 64'd0);
            return;
         end
         if (wasValid && r) expIdx++;
         if (expIdx == 33) begin
            checkOutput({name, " done pulse"}, 64'(done), 64'd1);
            checkOutput({name, " valid drop"}, 64'(rk_valid), 64'd0);
            if (!randomStall) checkOutput({name, " done cycle"}, 64'(cycles), 64'd33);
            applyStimulus(1'b0, 1'b0, 1'b0, key);
            checkOutput({name, " done one cycle"}, 64'(done), 64'd0);
            checkOutput({name, " back idle"}, 64'(busy), 64'd0);
            completed = 1'b1;
            break;
         end
      end
      if (!completed) checkOutput({name, " finished in budget"}, 64'd0, 64'd1);
   endtask

   initial begin
      bit ok;
      rst      = 1'b1;
      start    = 1'b0;
      abort    = 1'b0;
      rk_ready = 1'b0;
      key_in   = '0;
      applyStimulus(1'b0, 1'b0, 1'b0, KEY_ZERO);
      applyStimulus(1'b0, 1'b0, 1'b0, KEY_ZERO);
      checkOutput("reset busy", 64'(busy), 64'd0);
      checkOutput("reset valid", 64'(rk_valid), 64'd0);
      checkOutput("reset done", 64'(done), 64'd0);
      checkOutput("reset key", round_key, 64'd0);
      checkOutput("reset index", 64'(rk_index), 64'd0);
      rst = 1'b0;

      $display("[TB] start+abort in IDLE");
      applyStimulus(1'b1, 1'b1, 1'b1, KEY_ONES);
      applyStimulus(1'b0, 1'b0, 1'b1, KEY_ONES);
      checkOutput("start+abort busy", 64'(busy), 64'd0);
      checkOutput("start+abort valid", 64'(rk_valid), 64'd0);
      checkOutput("start+abort key", round_key, 64'd0);

      $display("[TB] test 1: zero key");
      runSchedule(KEY_ZERO, 1'b0, 0, 0, KEY_ZERO, "t1", ok);
      checkOutput("t1 K1", gotKeys[1], 64'h0000000000000000);
      checkOutput("t1 K2", gotKeys[2], 64'hC000000000000000);
      checkOutput("t1 K32", gotKeys[32], 64'h6DAB31744F41D700);
      checkOutput("t1 ciphertext", encryptRef(64'h0), 64'h5579C1387B228445);

      $display("[TB] test 2: all-ones key");
      runSchedule(KEY_ONES, 1'b0, 0, 0, KEY_ZERO, "t2", ok);
      checkOutput("t2 K1", gotKeys[1], 64'hFFFFFFFFFFFFFFFF);
      checkOutput("t2 K2", gotKeys[2], 64'h2FFFFFFFFFFFFFFF);
      checkOutput("t2 ciphertext", encryptRef(64'h0), 64'hE72C46C0F5945049);

      $display("[TB] test 3: random stalls");
      runSchedule(KEY_ONES, 1'b1, 0, 0, KEY_ZERO, "t3", ok);
      checkOutput("t3 ciphertext", encryptRef(64'hFFFFFFFFFFFFFFFF), 64'h3333DCD3213210D2);

      $display("[TB] test 4: abort at index 10");
      runSchedule(KEY_ONES, 1'b0, 10, 2, KEY_ZERO, "t4", ok);
      runSchedule(KEY_ZERO, 1'b0, 0, 0, KEY_ZERO, "t4 restart", ok);
      checkOutput("t4 K1", gotKeys[1], 64'h0000000000000000);
      checkOutput("t4 K2", gotKeys[2], 64'hC000000000000000);

      $display("[TB] test 5: start during RUN");
      runSchedule(KEY_ZERO, 1'b0, 5, 1, KEY_ONES, "t5", ok);
      checkOutput("t5 ciphertext", encryptRef(64'hFFFFFFFFFFFFFFFF), 64'hA112FFC72F68417B);

      $display("[TB] test 6: reset at index 20");
      runSchedule(KEY_ZERO, 1'b0, 20, 3, KEY_ZERO, "t6", ok);
      runSchedule(KEY_ONES, 1'b0, 0, 0, KEY_ZERO, "t6 restart", ok);
      checkOutput("t6 ciphertext", encryptRef(64'h0), 64'hE72C46C0F5945049);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
